// File: rtl/imx_sync_pattern_gen.sv
// Sony sub-LVDS sensor emulator: per-lane 12-bit word streams with SAV/EAV sync codes,
// blanking lines and test-pattern pixel data for exercising the capture path.
module imx_sync_pattern_gen #(
    parameter int          LANES      = 8,
    parameter int          H_ACTIVE   = 64,
    parameter int          H_BLANK    = 16,
    parameter int          V_ACTIVE   = 8,
    parameter int          V_BLANK    = 2,
    parameter logic [11:0] BLANK_CODE = 12'h040
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    output logic [LANES*12-1:0]   dout,
    output logic                  dvalid,
    output logic                  line_start,
    output logic                  frame_start,
    output logic                  busy
);

    localparam int WMAX  = (H_ACTIVE > H_BLANK) ? ((H_ACTIVE > 4) ? H_ACTIVE : 4)
                                                : ((H_BLANK > 4) ? H_BLANK : 4);
    localparam int WW    = $clog2(WMAX);
    localparam int LINES = V_BLANK + V_ACTIVE;
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [WW-1:0] HA_LAST   = WW'(H_ACTIVE - 1);
    localparam logic [WW-1:0] HB_LAST   = WW'(H_BLANK - 1);
    localparam logic [WW-1:0] SYNC_LAST = WW'(3);
    localparam logic [LW-1:0] L_LAST    = LW'(LINES - 1);
    localparam logic [LW-1:0] VB        = LW'(V_BLANK);
    localparam logic [11:0]   LANES_12  = 12'(LANES);

    typedef enum logic [2:0] {IDLE, SAV, ACTIVE, EAV, HBLANK} state_t;

    state_t              state, state_n;
    logic [WW-1:0]       wcnt, wcnt_n;
    logic [LW-1:0]       lcnt, lcnt_n;
    logic [1:0]          mode_q, mode_n;

    logic [LANES*12-1:0] dout_n;
    logic                dvalid_n, ls_n, fs_n, busy_n;

    // Borrow bit of (lcnt - V_BLANK) marks a blanking line; the low bits give y.
    logic [LW:0]         ydiff;
    logic                blank_line;
    logic [11:0]         x12, y12;

    assign ydiff      = {1'b0, lcnt} - {1'b0, VB};
    assign blank_line = ydiff[LW];
    assign y12        = 12'(ydiff[LW-1:0]);
    assign x12        = 12'(wcnt);

    function automatic logic [11:0] sync_word(input logic [1:0] idx, input logic [11:0] code);
        case (idx)
            2'd0:    sync_word = 12'hFFF;
            2'd1:    sync_word = 12'h000;
            2'd2:    sync_word = 12'h000;
            default: sync_word = code;
        endcase
    endfunction

    function automatic logic [11:0] clip(input logic [11:0] v);
        if (v == 12'h000)      clip = 12'h001;
        else if (v == 12'hFFF) clip = 12'hFFE;
        else                   clip = v;
    endfunction

    function automatic logic [11:0] pattern(input logic [1:0] m, input logic [11:0] x,
                                            input logic [11:0] lane, input logic [11:0] y);
        case (m)
            2'd0:    pattern = x * LANES_12 + lane + y;
            2'd1:    pattern = 12'h800;
            2'd2:    pattern = y;
            default: pattern = {lane[3:0], x[7:0]};
        endcase
    endfunction

    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        lcnt_n   = lcnt;
        mode_n   = mode_q;
        dout_n   = {LANES{BLANK_CODE}};
        dvalid_n = 1'b0;
        ls_n     = 1'b0;
        fs_n     = 1'b0;
        busy_n   = (state != IDLE);

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = SAV;
                    wcnt_n  = '0;
                    lcnt_n  = '0;
                    mode_n  = mode;
                end
            end

            SAV: begin
                dout_n = {LANES{sync_word(wcnt[1:0], blank_line ? 12'hAB0 : 12'h800)}};
                ls_n   = (wcnt == '0);
                fs_n   = (wcnt == '0) && (lcnt == '0);
                if (wcnt == SYNC_LAST) begin
                    state_n = ACTIVE;
                    wcnt_n  = '0;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end

            ACTIVE: begin
                if (!blank_line) begin
                    dvalid_n = 1'b1;
                    for (int unsigned l = 0; l < LANES; l++) begin
                        dout_n[12*l +: 12] = clip(pattern(mode_q, x12, 12'(l), y12));
                    end
                end
                if (wcnt == HA_LAST) begin
                    state_n = EAV;
                    wcnt_n  = '0;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end

            EAV: begin
                dout_n = {LANES{sync_word(wcnt[1:0], blank_line ? 12'hB60 : 12'h9D0)}};
                if (wcnt == SYNC_LAST) begin
                    state_n = HBLANK;
                    wcnt_n  = '0;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end

            HBLANK: begin
                if (wcnt == HB_LAST) begin
                    wcnt_n = '0;
                    if (lcnt == L_LAST) begin
                        lcnt_n = '0;
                        if (enable) begin
                            state_n = SAV;
                            mode_n  = mode;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        lcnt_n  = lcnt + LW'(1);
                        state_n = SAV;
                    end
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wcnt        <= '0;
            lcnt        <= '0;
            mode_q      <= '0;
            dout        <= {LANES{BLANK_CODE}};
            dvalid      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            wcnt        <= wcnt_n;
            lcnt        <= lcnt_n;
            mode_q      <= mode_n;
            dout        <= dout_n;
            dvalid      <= dvalid_n;
            line_start  <= ls_n;
            frame_start <= fs_n;
            busy        <= busy_n;
        end
    end

endmodule
